// File: rtl/vx_afu_pkg.sv
// Shared types for the AFU run controller: lifecycle state encoding and
// the default per-bank pending-write counter width.
package vx_afu_pkg;

  localparam int AFU_PENDING_WIDTH = 12;

  typedef enum logic [2:0] {
    AFU_IDLE      = 3'd0,
    AFU_INIT      = 3'd1,
    AFU_WAIT_BUSY = 3'd2,
    AFU_RUN       = 3'd3,
    AFU_DRAIN     = 3'd4,
    AFU_DONE      = 3'd5
  } afu_run_state_e;

endpackage

// File: rtl/vx_afu_pending_ctr.sv
// Saturating outstanding-write counter for one memory bank; flags throttle
// at the limit and pulses err on an overflow or underflow attempt.
module vx_afu_pending_ctr
  import vx_afu_pkg::*;
#(
  parameter int WIDTH       = AFU_PENDING_WIDTH,
  parameter int MAX_PENDING = 2048
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             throttle,
  output logic             err
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_PENDING);

  logic inc_only;
  logic dec_only;

  assign inc_only = inc && !dec;
  assign dec_only = dec && !inc;

  // A simultaneous request and response cancel out, even at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc_only && (count < LIMIT)) begin
      count <= count + WIDTH'(1);
    end else if (dec_only && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign throttle = (count >= LIMIT);
  assign err      = (inc_only && (count >= LIMIT)) || (dec_only && (count == '0));

endmodule

// File: rtl/vx_afu_run_ctrl.sv
// Kernel-lifecycle sequencer for the XRT AFU wrapper with per-bank write
// tracking. Optional RUN watchdog enabled by defining VX_AFU_WATCHDOG_EN.
module vx_afu_run_ctrl
  import vx_afu_pkg::*;
#(
  parameter int NUM_BANKS      = 1,
  parameter int RESET_DELAY    = 16,
  parameter int PENDING_WIDTH  = AFU_PENDING_WIDTH,
  parameter int MAX_PENDING    = 2048,
  parameter int TIMEOUT_CYCLES = 2 ** 24,
  localparam int TOTAL_W       = PENDING_WIDTH + $clog2(NUM_BANKS + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 ap_start,
  input  logic                 ap_reset,
  input  logic                 ap_ctrl_read,
  input  logic                 vx_busy,
  input  logic [NUM_BANKS-1:0] wr_req_fire,
  input  logic [NUM_BANKS-1:0] wr_rsp_fire,
  output logic                 vx_reset,
  output logic                 ap_idle,
  output logic                 ap_done,
  output logic                 ap_ready,
  output logic [NUM_BANKS-1:0] wr_throttle,
  output logic [TOTAL_W-1:0]   pending_total,
  output logic [2:0]           state,
  output logic                 err_underflow,
  output logic                 timeout
);

  localparam int RST_W = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_DELAY - 1);

  afu_run_state_e           cur_state, nxt_state;
  logic [RST_W-1:0]         rst_cnt, nxt_rst_cnt;
  logic                     vx_reset_q, nxt_vx_reset;
  logic                     err_q, timeout_q, wd_expire;
  logic [NUM_BANKS-1:0]     bank_err;
  logic [PENDING_WIDTH-1:0] bank_cnt [NUM_BANKS];
  logic [TOTAL_W-1:0]       sum_cnt;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    vx_afu_pending_ctr #(
      .WIDTH       (PENDING_WIDTH),
      .MAX_PENDING (MAX_PENDING)
    ) u_ctr (
      .clk      (clk),
      .resetn   (resetn),
      .inc      (wr_req_fire[g]),
      .dec      (wr_rsp_fire[g]),
      .count    (bank_cnt[g]),
      .throttle (wr_throttle[g]),
      .err      (bank_err[g])
    );
  end

  always_comb begin
    sum_cnt = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      sum_cnt = sum_cnt + TOTAL_W'(bank_cnt[i]);
    end
  end

`ifdef VX_AFU_WATCHDOG_EN
  logic [31:0] wd_cnt;

  // Held at zero outside RUN, so it restarts on every RUN entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt <= '0;
    end else if (cur_state != AFU_RUN) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 32'd1;
    end
  end

  assign wd_expire = (cur_state == AFU_RUN) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  wire unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_state  <= AFU_IDLE;
      rst_cnt    <= '0;
      vx_reset_q <= 1'b1;
    end else begin
      cur_state  <= nxt_state;
      rst_cnt    <= nxt_rst_cnt;
      vx_reset_q <= nxt_vx_reset;
    end
  end

  // DRAIN looks at the live counters because pending_total is one cycle stale.
  always_comb begin
    nxt_state    = cur_state;
    nxt_rst_cnt  = rst_cnt;
    nxt_vx_reset = vx_reset_q;
    unique case (cur_state)
      AFU_IDLE: begin
        if (ap_start) begin
          nxt_state    = AFU_INIT;
          nxt_rst_cnt  = RST_LOAD;
          nxt_vx_reset = 1'b1;
        end
      end
      AFU_INIT: begin
        if (rst_cnt == '0) begin
          nxt_state    = AFU_WAIT_BUSY;
          nxt_vx_reset = 1'b0;
        end else begin
          nxt_rst_cnt = rst_cnt - RST_W'(1);
        end
      end
      AFU_WAIT_BUSY: begin
        if (vx_busy) nxt_state = AFU_RUN;
      end
      AFU_RUN: begin
        if (wd_expire) begin
          nxt_state    = AFU_DRAIN;
          nxt_vx_reset = 1'b1;
        end else if (!vx_busy) begin
          nxt_state = AFU_DRAIN;
        end
      end
      AFU_DRAIN: begin
        if (sum_cnt == '0) nxt_state = AFU_DONE;
      end
      AFU_DONE: begin
        if (ap_ctrl_read) nxt_state = AFU_IDLE;
      end
      default: nxt_state = AFU_IDLE;
    endcase
    if (ap_reset) begin
      nxt_state    = AFU_IDLE;
      nxt_vx_reset = 1'b1;
    end
  end

  // Counters and sticky flags deliberately survive ap_reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending_total <= '0;
      err_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      pending_total <= sum_cnt;
      err_q         <= err_q | (|bank_err);
      timeout_q     <= timeout_q | (wd_expire && !ap_reset);
    end
  end

  assign vx_reset      = vx_reset_q;
  assign state         = cur_state;
  assign ap_idle       = (cur_state == AFU_IDLE);
  assign ap_done       = (cur_state == AFU_DONE);
  assign ap_ready      = ap_done;
  assign err_underflow = err_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_vx_afu_run_ctrl.sv
// Randomized scoreboard bench for vx_afu_run_ctrl (2 banks, limit 4) against
// a lifecycle reference model kept in plain integers.
module tb_vx_afu_run_ctrl;

  localparam int NB   = 2;
  localparam int RD   = 16;
  localparam int PW   = 12;
  localparam int MP   = 4;
  localparam int TOTW = PW + $clog2(NB + 1);

  logic            clk = 1'b0;
  logic            resetn, ap_start, ap_reset, ap_ctrl_read, vx_busy;
  logic [NB-1:0]   wr_req_fire, wr_rsp_fire;
  logic            vx_reset, ap_idle, ap_done, ap_ready, err_underflow, timeout;
  logic [NB-1:0]   wr_throttle;
  logic [TOTW-1:0] pending_total;
  logic [2:0]      state;

  typedef struct {
    int cyc;
    int st;
    int vxr;
    int idle;
    int done;
    int ready;
    int thr;
    int pt;
    int err;
    int tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  int m_state, m_age, m_vxr, m_err, m_pt;
  int m_cnt [NB];

  always #5 clk = ~clk;

  vx_afu_run_ctrl #(
    .NUM_BANKS      (NB),
    .RESET_DELAY    (RD),
    .PENDING_WIDTH  (PW),
    .MAX_PENDING    (MP),
    .TIMEOUT_CYCLES (2 ** 24)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ap_start      (ap_start),
    .ap_reset      (ap_reset),
    .ap_ctrl_read  (ap_ctrl_read),
    .vx_busy       (vx_busy),
    .wr_req_fire   (wr_req_fire),
    .wr_rsp_fire   (wr_rsp_fire),
    .vx_reset      (vx_reset),
    .ap_idle       (ap_idle),
    .ap_done       (ap_done),
    .ap_ready      (ap_ready),
    .wr_throttle   (wr_throttle),
    .pending_total (pending_total),
    .state         (state),
    .err_underflow (err_underflow),
    .timeout       (timeout)
  );

  task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, c, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("state", e.cyc, 32'(state), e.st);
    cmp("vx_reset", e.cyc, 32'(vx_reset), e.vxr);
    cmp("ap_idle", e.cyc, 32'(ap_idle), e.idle);
    cmp("ap_done", e.cyc, 32'(ap_done), e.done);
    cmp("ap_ready", e.cyc, 32'(ap_ready), e.ready);
    cmp("wr_throttle", e.cyc, 32'(wr_throttle), e.thr);
    cmp("pending_total", e.cyc, 32'(pending_total), e.pt);
    cmp("err_underflow", e.cyc, 32'(err_underflow), e.err);
    cmp("timeout", e.cyc, 32'(timeout), e.tmo);
  endtask

  task automatic pushExpected();
    exp_t e;
    int thr = 0;
    for (int i = 0; i < NB; i++) if (m_cnt[i] >= MP) thr |= (1 << i);
    e.cyc   = cyc;
    e.st    = m_state;
    e.vxr   = m_vxr;
    e.idle  = (m_state == 0);
    e.done  = (m_state == 5);
    e.ready = (m_state == 5);
    e.thr   = thr;
    e.pt    = m_pt;
    e.err   = m_err;
    e.tmo   = 0;
    exp_q.push_back(e);
  endtask

  // Drives one cycle of inputs, advances the reference model across the
  // coming clock edge and queues what the DUT should show after it.
  task automatic applyStimulus(input bit rst_low, input int p_req, input int p_rsp,
                               input bit allow_err, input int p_reset);
    int  total;
    bit  rq, rs;
    cyc++;
    if (rst_low) begin
      resetn = 1'b0; ap_start = 1'b0; ap_reset = 1'b0; ap_ctrl_read = 1'b0;
      vx_busy = 1'b0; wr_req_fire = '0; wr_rsp_fire = '0;
      m_state = 0; m_age = 0; m_vxr = 1; m_err = 0; m_pt = 0;
      for (int i = 0; i < NB; i++) m_cnt[i] = 0;
      pushExpected();
      return;
    end
    resetn       = 1'b1;
    ap_start     = ($urandom_range(99) < 30);
    ap_ctrl_read = ($urandom_range(99) < 20);
    ap_reset     = ($urandom_range(999) < p_reset);
    if ($urandom_range(99) < 12) vx_busy = !vx_busy;
    for (int i = 0; i < NB; i++) begin
      rq = ($urandom_range(99) < p_req);
      rs = ($urandom_range(99) < p_rsp);
      if (!allow_err && rs && !rq && m_cnt[i] == 0) rs = 1'b0;
      if (!allow_err && rq && !rs && m_cnt[i] >= MP) rq = 1'b0;
      wr_req_fire[i] = rq;
      wr_rsp_fire[i] = rs;
    end

    total = 0;
    for (int i = 0; i < NB; i++) total += m_cnt[i];

    if (ap_reset) begin
      m_state = 0;
      m_vxr   = 1;
    end else begin
      case (m_state)
        0: if (ap_start) begin m_state = 1; m_age = 0; m_vxr = 1; end
        1: begin
          m_age++;
          if (m_age == RD) begin m_state = 2; m_vxr = 0; end
        end
        2: if (vx_busy) m_state = 3;
        3: if (!vx_busy) m_state = 4;
        4: if (total == 0) m_state = 5;
        5: if (ap_ctrl_read) m_state = 0;
        default: m_state = 0;
      endcase
    end

    for (int i = 0; i < NB; i++) begin
      if (wr_req_fire[i] && !wr_rsp_fire[i]) begin
        if (m_cnt[i] >= MP) m_err = 1; else m_cnt[i]++;
      end else if (wr_rsp_fire[i] && !wr_req_fire[i]) begin
        if (m_cnt[i] == 0) m_err = 1; else m_cnt[i]--;
      end
    end
    m_pt = total;
    pushExpected();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  typedef struct {
    int  cycles;
    int  p_req;
    int  p_rsp;
    bit  allow_err;
    int  p_reset;
    bit  reset_before;
  } phase_t;

  phase_t phases [5] = '{
    '{800, 30, 30, 1'b0, 5,  1'b0},
    '{800, 60, 25, 1'b0, 5,  1'b0},
    '{800, 20, 50, 1'b1, 10, 1'b0},
    '{600, 30, 30, 1'b0, 5,  1'b1},
    '{600, 35, 35, 1'b1, 3,  1'b0}
  };

  initial begin
    resetn = 1'b0; ap_start = 1'b0; ap_reset = 1'b0; ap_ctrl_read = 1'b0;
    vx_busy = 1'b0; wr_req_fire = '0; wr_rsp_fire = '0;
    $display("[TB] start");
    repeat (3) begin
      @(negedge clk);
      applyStimulus(1'b1, 0, 0, 1'b0, 0);
    end
    foreach (phases[p]) begin
      if (phases[p].reset_before) begin
        repeat (2) begin
          @(negedge clk);
          applyStimulus(1'b1, 0, 0, 1'b0, 0);
        end
      end
      for (int c = 0; c < phases[p].cycles; c++) begin
        @(negedge clk);
        applyStimulus(1'b0, phases[p].p_req, phases[p].p_rsp,
                      phases[p].allow_err, phases[p].p_reset);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    cmp("scoreboard_drained", cyc, 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vx_afu_run_ctrl.md
Name: vx_afu_run_ctrl

Overview:
Kernel-lifecycle sequencer for the XRT AFU wrapper. It steps the Vortex core through reset, run and write-drain phases, and drives the ap_* control handshake toward the AXI-Lite control block. It also tracks outstanding AXI writes per memory bank and throttles AW issue when a bank reaches its limit. It replaces the ad-hoc state/pending-write logic in the AFU wrapper with a single reusable controller.

Parameters:
NUM_BANKS, 1, number of AXI memory banks tracked
RESET_DELAY, 16, cycles vx_reset is held after entering INIT (>=1)
PENDING_WIDTH, 12, per-bank outstanding-write counter width
MAX_PENDING, 2048, per-bank outstanding-write limit (<= 2^PENDING_WIDTH-1)
TIMEOUT_CYCLES, 2^24, watchdog limit in RUN (used only with the optional feature)

Ports:
clk  in  1  clock
resetn  in  1  async active-low reset
ap_start  in  1  host start pulse, sampled in IDLE only
ap_reset  in  1  host soft reset, synchronous, any state
ap_ctrl_read  in  1  host read of the ap_ctrl register (done acknowledge)
vx_busy  in  1  core busy indication
wr_req_fire  in  NUM_BANKS  per-bank completed write request (AW+W accepted)
wr_rsp_fire  in  NUM_BANKS  per-bank B response handshake
vx_reset  out  1  core reset
ap_idle  out  1  state==IDLE
ap_done  out  1  state==DONE
ap_ready  out  1  equals ap_done
wr_throttle  out  NUM_BANKS  bank i must not raise awvalid
pending_total  out  PENDING_WIDTH+CLOG2(NUM_BANKS+1)  sum of per-bank counters
state  out  3  current state (debug/scope)
err_underflow  out  1  sticky: B response with zero pending
timeout  out  1  sticky watchdog flag (tied 0 when the feature is off)

Behaviour:
- resetn low (async): state=IDLE, vx_reset=1, all counters 0, all sticky flags 0, wr_throttle=0.
- States: IDLE(0), INIT(1), WAIT_BUSY(2), RUN(3), DRAIN(4), DONE(5).
- IDLE: ap_start -> INIT on the next cycle; load reset counter to RESET_DELAY-1; vx_reset stays 1.
- INIT: counter decrements each cycle. Whenever counter==0, vx_reset<=0 and state->WAIT_BUSY. Net effect: vx_reset falls exactly RESET_DELAY cycles after INIT entry.
- WAIT_BUSY: vx_busy -> RUN.
- RUN: ~vx_busy -> DRAIN.
- DRAIN: pending_total==0 -> DONE. If the count is already 0 on entry, DONE follows one cycle later.
- DONE: ap_ctrl_read -> IDLE. vx_reset is not reasserted until the next ap_start.
- ap_reset, any state: next state=IDLE, vx_reset=1. Pending counters and sticky flags are NOT cleared, because in-flight B responses must still be counted. ap_reset has priority over every transition.
- Per-bank counter i: +1 on wr_req_fire[i], -1 on wr_rsp_fire[i]; simultaneous fire leaves it unchanged.
- Underflow: rsp with count 0 holds the counter at 0 and sets err_underflow.
- Overflow: req with count==MAX_PENDING holds the counter and sets err_underflow (shared error flag).
- wr_throttle[i] is combinational: count[i] >= MAX_PENDING.
- pending_total is registered and lags the counters by one cycle. The DRAIN exit therefore uses the combinational sum of the updated counters, not pending_total.
- ap_idle, ap_done and ap_ready are combinational from state only.

Optional Feature:
VX_AFU_WATCHDOG_EN
- Defined: a 32-bit cycle counter clears on RUN entry and increments in RUN. When it reaches TIMEOUT_CYCLES: timeout<=1 (sticky), state->DRAIN, vx_reset<=1 so the core is forced quiet.
- Not defined: no counter is built, timeout is tied 0, and RUN exits only on ~vx_busy.

Decomposition:
- Package vx_afu_pkg: afu_run_state_e enum (3-bit), AFU_PENDING_WIDTH default constant.
- Sub-module vx_afu_pending_ctr: one saturating up/down counter with throttle and error outputs. Instantiate it once per bank in a generate loop; the controller sums the counts.

Test Plan:
- Basic run, RESET_DELAY=16: ap_start@t0 -> vx_reset falls at t0+17. Raise vx_busy for 100 cycles -> RUN, then DRAIN, then DONE. ap_ctrl_read -> ap_idle=1 on the next cycle.
- Drain wait: 5 wr_req_fire on bank0 during RUN, vx_busy falls -> stays in DRAIN. After 5 wr_rsp_fire, ap_done=1 exactly one cycle after the last rsp.
- Throttle, MAX_PENDING=4, NUM_BANKS=2: 4 reqs on bank1 -> wr_throttle=2'b10. Simultaneous req+rsp on bank1 -> count stays 4. One rsp -> wr_throttle=0.
- Underflow: wr_rsp_fire[0] with count 0 -> err_underflow=1, count stays 0. The flag persists through ap_reset and clears only on resetn.
- Mid-run ap_reset with 3 pending -> IDLE and vx_reset=1 next cycle, pending_total still 3. The 3 later rsps bring it to 0.
- With VX_AFU_WATCHDOG_EN, TIMEOUT_CYCLES=50, vx_busy held 1 -> timeout=1 at cycle 50 of RUN, state=DRAIN, vx_reset=1.
